round_key_stream_xor: RTL and testbench
=======================================

// Module: round_key_stream_xor
// PURPOSE
//  Parametrised successor to the combinational AddRoundKey stage: holds the AES cipher key, expands the schedule on the fly
//  (one 32-bit word per clock) and XORs each successive 128-bit round key into a state presented over a valid/ready handshake.
//  Sits between the round datapath (SubBytes/ShiftRows/MixColumns) and the round controller; supports AES-128/192/256.
//  State/word packing unchanged: word c = bits [127-32c -: 32], byte S(r,c) = bits [127-32c-8r -: 8].
// PARAMETERS
//  NK   4   key length in 32-bit words; legal values 4, 6, 8 (elaboration $error otherwise)
//  NR   NK+6  number of rounds (localparam, derived); round index runs 0..NR
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high
//  key_load   in   1       1-cycle pulse: capture key, round index <- 0, abort any transaction
//  key        in   NK*32   cipher key; word 0 = key[NK*32-1 -: 32]
//  in_valid   in   1       state_in valid
//  in_ready   out  1       engine can accept a state
//  state_in   in   128     state to be keyed
//  out_valid  out  1       new_state valid
//  out_ready  in   1       downstream accepts new_state
//  new_state  out  128     state_in ^ round key[round]
//  out_round  out  4       round index used for new_state
//  out_last   out  1       out_round == NR
//  key_valid  out  1       a key has been loaded since reset
// BEHAVIOUR
//  - Reset: in_ready=0, out_valid=0, new_state=0, out_round=0, out_last=0, key_valid=0; FSM->NOKEY; key regs cleared.
//  - FSM: NOKEY -(key_load)-> IDLE -(in_valid&in_ready)-> GEN -(4th word)-> OUT -(out_ready)-> IDLE.
//  - in_ready=1 only in IDLE. Accept captures state_in; GEN emits words 4r..4r+3 in 4 cycles; out_valid asserts
//    the cycle after the 4th word (accept-to-out_valid latency = 5 clocks). Words i<NK come straight from the key copy.
//  - Word gen: window of last NK words; w[i]=w[i-NK]^t; t=SubWord(RotWord(w[i-1]))^{Rcon[i/NK],24'h0} if i%NK==0;
//    t=SubWord(w[i-1]) if NK==8 and i%NK==4; else t=w[i-1]. Rcon=01,02,04,08,10,20,40,80,1b,36. SubWord uses 4
//    instances of the codebase's combinational 8-bit sbox. Word counter width 6 bits (max 4*(NR+1)-1 = 59).
//  - new_state, out_round, out_last held stable while out_valid & !out_ready.
//  - After handshake with out_last=1: round index and word counter wrap to 0, window reloaded from stored key copy
//    (same cycle); next transaction uses round 0 key. No extra latency on wrap.
//  - key_load in any state (incl. GEN/OUT mid-transaction): next cycle out_valid=0, pending state discarded, FSM=IDLE,
//    round=0, key_valid=1. key_load concurrent with in_valid: load wins, in_ready was low or is ignored (no accept).
//  - in_valid while in NOKEY: ignored, in_ready=0. Reset mid-transaction: immediate return to reset values.
//  - No back-pressure combinational paths: in_ready and out_valid are registered-state decodes only.
// CONFIGURATION
//  ROUND_KEY_OUT_EN defined: adds output round_key [127:0], = the 128-bit key used for new_state, valid and held with
//    out_valid, 0 at reset. Undefined: port absent; key words discarded after XOR (no 128-bit rk register beyond the
//    collect buffer).
// TESTING
//  1 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, state 3243f6a8885a308d313198a2e0370734 -> new_state
//    193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_valid 5 clocks after accept.
//  2 NK=4, key 000102030405060708090a0b0c0d0e0f, 11 zero states -> 11th output (round 10, out_last=1)
//    13111d7fe3944a17f307a78b4d2b30c5; 12th output round 0 = key again (wrap).
//  3 NK=8, key 000102...1e1f, 15 zero states -> round 14 output 24fc79ccbf0979e9371ac23c6d68de36, out_last=1.
//  4 Hold out_ready=0 for 7 cycles in OUT -> new_state/out_round stable, in_ready=0; release -> one handshake only.
//  5 key_load pulse during GEN cycle 2 of round 3 -> out_valid never rises for that state; next accept yields round 0.
//  6 Assert reset asynchronously mid-OUT (between edges) -> out_valid/key_valid drop immediately; in_valid ignored till key_load.

Source files
------------

// File: rtl/round_key_stream_xor.sv
// Streaming AddRoundKey for AES-128/192/256: expands one schedule word per clock and XORs each round key into a handshaked state.
// Optional ROUND_KEY_OUT_EN adds a round_key output holding the 128-bit key applied to new_state.
//
// state | meaning
// NOKEY | no key loaded since reset, nothing accepted
// IDLE  | key present, in_ready high
// GEN   | phases 0-3 produce one schedule word each and XOR it in; phase 4 settles the result
// OUT   | new_state valid, held until out_ready

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign q = SBOX[a];
endmodule

module round_key_stream_xor #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_load,
  input  logic [NK*32-1:0]  key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      state_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      new_state,
  output logic [3:0]        out_round,
  output logic              out_last,
  output logic              key_valid
`ifdef ROUND_KEY_OUT_EN
  ,
  output logic [127:0]      round_key
`endif
);

  localparam int NR = NK + 6;
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [2:0] KPOS_L = 3'(NK - 1);
  localparam logic [3:0] NR_W   = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
    $error("round_key_stream_xor: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {S_NOKEY, S_IDLE, S_GEN, S_OUT} state_t;

  state_t       state, state_nxt;
  logic [2:0]   phase;
  logic [31:0]  kcopy [NK];
  logic [31:0]  win   [NK];
  logic [5:0]   wcnt;
  logic [2:0]   kpos;
  logic [3:0]   rci;
  logic [3:0]   rnd;
  logic [127:0] st;
`ifdef ROUND_KEY_OUT_EN
  logic [127:0] rk;
`endif

  logic         accept, gen_word, out_hs;
  logic [31:0]  w_prev, sb_in, sb_out, t_word, new_word;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);
  assign key_valid = (state != S_NOKEY);
  assign new_state = st;
  assign out_round = rnd;
  assign out_last  = (rnd == NR_W);
`ifdef ROUND_KEY_OUT_EN
  assign round_key = rk;
`endif

  assign accept   = in_ready && in_valid && !key_load;
  assign gen_word = (state == S_GEN) && !phase[2];
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_NOKEY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_NOKEY: state_nxt = S_NOKEY;
        S_IDLE:  if (in_valid) state_nxt = S_GEN;
        S_GEN:   if (phase[2]) state_nxt = S_OUT;
        S_OUT:   if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_NOKEY;
      endcase
    end
  end

  // Window holds the last NK words: win[0] = w[i-NK], win[NK-1] = w[i-1].
  assign w_prev = win[NK-1];
  assign sb_in  = (kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .q(sb_out[8*b +: 8]));
  end

  always_comb begin
    t_word = w_prev;
    if (kpos == 3'd0)                 t_word = sb_out ^ {rcon(rci), 24'h0};
    else if (NK == 8 && kpos == 3'd4) t_word = sb_out;
    // The first NK words are the key itself; rotating the window replays them.
    new_word = (wcnt < NK_W) ? win[0] : (win[0] ^ t_word);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NK; j++) begin
        kcopy[j] <= '0;
        win[j]   <= '0;
      end
      phase <= '0;
      wcnt  <= '0;
      kpos  <= '0;
      rci   <= '0;
      rnd   <= '0;
      st    <= '0;
`ifdef ROUND_KEY_OUT_EN
      rk    <= '0;
`endif
    end else if (key_load) begin
      for (int j = 0; j < NK; j++) begin
        kcopy[j] <= key[NK*32-1-32*j -: 32];
        win[j]   <= key[NK*32-1-32*j -: 32];
      end
      phase <= '0;
      wcnt  <= '0;
      kpos  <= '0;
      rci   <= '0;
      rnd   <= '0;
    end else begin
      if (accept) begin
        st    <= state_in;
        phase <= '0;
      end
      if (gen_word) begin
        for (int c = 0; c < 4; c++) begin
          if (phase == 3'(c)) begin
            st[127-32*c -: 32] <= st[127-32*c -: 32] ^ new_word;
`ifdef ROUND_KEY_OUT_EN
            rk[127-32*c -: 32] <= new_word;
`endif
          end
        end
        for (int j = 0; j < NK-1; j++) win[j] <= win[j+1];
        win[NK-1] <= new_word;
        wcnt  <= wcnt + 6'd1;
        phase <= phase + 3'd1;
        if (kpos == KPOS_L) begin
          kpos <= '0;
          rci  <= rci + 4'd1;
        end else begin
          kpos <= kpos + 3'd1;
        end
      end
      if (out_hs) begin
        if (out_last) begin
          // Schedule restarts from the stored key in the handshake cycle, so round 0 follows with no gap.
          for (int j = 0; j < NK; j++) win[j] <= kcopy[j];
          rnd  <= '0;
          wcnt <= '0;
          kpos <= '0;
          rci  <= '0;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_key_stream_xor.sv
// Directed bench for round_key_stream_xor: one NK=4 and one NK=8 instance checked against FIPS-197 schedule values.
module tb_round_key_stream_xor;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_load  [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] state_in  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] new_state [2];
  logic [3:0]   out_round [2];
  logic         out_last  [2];
  logic         key_valid [2];
  logic [127:0] key_a;
  logic [255:0] key_b;
`ifdef ROUND_KEY_OUT_EN
  logic [127:0] rk_a, rk_b;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  round_key_stream_xor #(.NK(4)) u_dut_a (
    .clk(clk), .reset(reset), .key_load(key_load[0]), .key(key_a),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state_in(state_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .new_state(new_state[0]),
    .out_round(out_round[0]), .out_last(out_last[0]), .key_valid(key_valid[0])
`ifdef ROUND_KEY_OUT_EN
    , .round_key(rk_a)
`endif
  );

  round_key_stream_xor #(.NK(8)) u_dut_b (
    .clk(clk), .reset(reset), .key_load(key_load[1]), .key(key_b),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state_in(state_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .new_state(new_state[1]),
    .out_round(out_round[1]), .out_last(out_last[1]), .key_valid(key_valid[1])
`ifdef ROUND_KEY_OUT_EN
    , .round_key(rk_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d);
    key_load[d] = 1'b1;
    tick();
    key_load[d] = 1'b0;
  endtask

  task automatic accept_wait(input int d, input logic [127:0] s, output int lat);
    int n = 0;
    while (!in_ready[d] && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 128'(in_ready[d]), 128'd1);
    in_valid[d] = 1'b1;
    state_in[d] = s;
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 20) begin
      tick();
      lat++;
    end
    chk("out_valid_wait", 128'(out_valid[d]), 128'd1);
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  task automatic xact(input int d, input logic [127:0] s, output logic [127:0] ns,
                      output logic [3:0] rd, output logic lst, output int lat);
    accept_wait(d, s, lat);
    ns  = new_state[d];
    rd  = out_round[d];
    lst = out_last[d];
    take(d);
  endtask

  initial begin
    logic [127:0] ns;
    logic [3:0]   rd;
    logic         lst;
    int           lat;
    logic         seen;

    for (int d = 0; d < 2; d++) begin
      key_load[d] = 1'b0;
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b0;
      state_in[d] = '0;
    end
    key_a = '0;
    key_b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(in_ready[0]),  128'd0);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_new_state", new_state[0],       128'd0);
    chk("rst_out_round", 128'(out_round[0]), 128'd0);
    chk("rst_out_last",  128'(out_last[0]),  128'd0);
    chk("rst_key_valid", 128'(key_valid[0]), 128'd0);
    reset = 1'b0;
    tick();

    in_valid[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("nokey_in_ready",  128'(in_ready[0]),  128'd0);
      chk("nokey_out_valid", 128'(out_valid[0]), 128'd0);
    end
    in_valid[0] = 1'b0;

    // FIPS-197 appendix B first AddRoundKey
    key_a = FIPS_KEY;
    load(0);
    chk("load_key_valid", 128'(key_valid[0]), 128'd1);
    chk("load_in_ready",  128'(in_ready[0]),  128'd1);
    xact(0, FIPS_PT, ns, rd, lst, lat);
    chk("t1_new_state", ns, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("t1_round",     128'(rd), 128'd0);
    chk("t1_last",      128'(lst), 128'd0);
    chk("t1_latency",   128'(lat), 128'd5);

    // back-pressure on round 1
    accept_wait(0, '0, lat);
    for (int k = 0; k < 7; k++) begin
      chk("hold_new_state", new_state[0],       128'ha0fafe1788542cb123a339392a6c7605);
      chk("hold_round",     128'(out_round[0]), 128'd1);
      chk("hold_in_ready",  128'(in_ready[0]),  128'd0);
      chk("hold_out_valid", 128'(out_valid[0]), 128'd1);
      tick();
    end
    take(0);
    chk("release_out_valid", 128'(out_valid[0]), 128'd0);
    chk("release_in_ready",  128'(in_ready[0]),  128'd1);
    xact(0, '0, ns, rd, lst, lat);
    chk("r2_new_state", ns, 128'hf2c295f27a96b9435935807a7359f67f);
    chk("r2_round",     128'(rd), 128'd2);

    // abort round 3 with key_load in GEN cycle 2
    in_valid[0] = 1'b1;
    state_in[0] = FIPS_PT;
    tick();
    in_valid[0] = 1'b0;
    tick();
    key_a = SEQ_KEY;
    key_load[0] = 1'b1;
    tick();
    key_load[0] = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      if (out_valid[0]) seen = 1'b1;
      tick();
    end
    chk("abort_no_out_valid", 128'(seen), 128'd0);
    chk("abort_in_ready",     128'(in_ready[0]), 128'd1);

    in_valid[0] = 1'b1;
    key_load[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    key_load[0] = 1'b0;
    chk("load_vs_valid_in_ready", 128'(in_ready[0]), 128'd1);

    // AES-128 full schedule with wrap (FIPS-197 C.1)
    for (int i = 0; i < 12; i++) begin
      xact(0, '0, ns, rd, lst, lat);
      chk("t2_round", 128'(rd), 128'(i % 11));
      chk("t2_last",  128'(lst), 128'(i == 10));
      if (i == 0)  chk("t2_r0",  ns, SEQ_KEY);
      if (i == 1)  chk("t2_r1",  ns, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      if (i == 10) chk("t2_r10", ns, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      if (i == 11) begin
        chk("t2_wrap_r0",  ns, SEQ_KEY);
        chk("t2_wrap_lat", 128'(lat), 128'd5);
      end
    end

    // AES-256 full schedule (FIPS-197 C.3)
    key_b = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    load(1);
    for (int i = 0; i < 15; i++) begin
      xact(1, '0, ns, rd, lst, lat);
      chk("t3_round", 128'(rd), 128'(i));
      chk("t3_last",  128'(lst), 128'(i == 14));
      if (i == 0)  chk("t3_r0",  ns, SEQ_KEY);
      if (i == 1)  chk("t3_r1",  ns, 128'h101112131415161718191a1b1c1d1e1f);
      if (i == 14) chk("t3_r14", ns, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    end

    // asynchronous reset while holding an output
    accept_wait(0, FIPS_PT, lat);
    #3;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 128'(out_valid[0]), 128'd0);
    chk("async_key_valid", 128'(key_valid[0]), 128'd0);
    chk("async_new_state", new_state[0],       128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_in_ready",  128'(in_ready[0]),  128'd0);
      chk("post_rst_out_valid", 128'(out_valid[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    load(0);
    chk("reload_key_valid", 128'(key_valid[0]), 128'd1);
    chk("reload_in_ready",  128'(in_ready[0]),  128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
